// File: rtl/v_instr_queue_if.sv
// Handshake bundle between the scalar-core feed, the vector instruction queue and v_sequencer.
// The slave modport is the queue side; the master modport is the core/sequencer side.
interface v_instr_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_funct6;
  logic          out_vm;
  logic [4:0]    out_vs2;
  logic [4:0]    out_vs1;
  logic [2:0]    out_funct3;
  logic [4:0]    out_vd;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_funct6, out_vm, out_vs2, out_vs1, out_funct3, out_vd,
           count, full, empty, illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_funct6, out_vm, out_vs2, out_vs1, out_funct3, out_vd,
           count, full, empty, illegal
  );
endinterface

// File: rtl/v_instr_queue.sv
// In-order RVV instruction FIFO with OP-V filtering and field pre-decode for v_sequencer.
// Optional V_IQ_BYPASS_EN: an empty queue forwards a legal incoming word in the same cycle.
module v_instr_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [6:0] OPV_CODE = 7'b1010111
) (
  input logic clk,
  input logic rst,
  input logic flush,
  v_instr_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0] funct6;
    logic       vm;
    logic [4:0] vs2;
    logic [4:0] vs1;
    logic [2:0] funct3;
    logic [4:0] vd;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               illegal_q, illegal_d;

  logic   empty, full, opv, accept, push, pop, wr_en, byp;
  entry_t in_entry, head;

  assign in_entry = entry_t'(bus.in_instr[31:7]);
  assign opv      = (bus.in_instr[6:0] == OPV_CODE);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

`ifdef V_IQ_BYPASS_EN
  assign byp = empty & bus.in_valid & opv;
`else
  assign byp = 1'b0;
`endif

  assign pop          = !empty & bus.out_ready;
  assign bus.in_ready = !full | pop;
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = accept & opv;
  // A bypassed word that the sequencer takes immediately never occupies a slot.
  assign wr_en        = push & !(byp & bus.out_ready);
  assign head         = byp ? in_entry : mem_q[rd_ptr_q];

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = accept & !opv;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      illegal_d = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid  = !empty | byp;
  assign bus.out_funct6 = head.funct6;
  assign bus.out_vm     = head.vm;
  assign bus.out_vs2    = head.vs2;
  assign bus.out_vs1    = head.vs1;
  assign bus.out_funct3 = head.funct3;
  assign bus.out_vd     = head.vd;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_v_instr_queue.sv
// Bench for v_instr_queue: directed vector table, flush/wrap/bypass sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_v_instr_queue;
  localparam int         DEPTH = 4;
  localparam logic [6:0] OPV   = 7'b1010111;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  v_instr_queue_if #(.DEPTH(DEPTH)) bus ();
  v_instr_queue #(.DEPTH(DEPTH), .OPV_CODE(OPV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  logic [25:0] head_w;
  assign head_w = {bus.out_funct6, bus.out_vm, bus.out_vs2, bus.out_vs1, bus.out_funct3, bus.out_vd};

  int total = 0;
  int bad   = 0;

  // Reference model: queued instruction bits [31:7], oldest first.
  logic [25:0] q[$];
  logic        ill_m;

  typedef struct {
    logic        iv;
    logic [31:0] w;
    logic        rdy;
    int          cnt;
    logic        ill;
    logic        ir;
    logic [31:0] hd;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [31:0] w, logic rdy, int cnt, logic ill,
                              logic ir, logic [31:0] hd);
    vec_t v;
    v.iv = iv; v.w = w; v.rdy = rdy; v.cnt = cnt; v.ill = ill; v.ir = ir; v.hd = hd;
    return v;
  endfunction

  function automatic logic [31:0] legal_word();
    logic [31:0] w;
    w      = $urandom();
    w[6:0] = OPV;
    return w;
  endfunction

  function automatic logic [31:0] illegal_word();
    logic [31:0] w;
    w      = $urandom();
    w[6:0] = 7'($urandom_range(0, 127));
    if (w[6:0] == OPV) w[6:0] = 7'h13;
    return w;
  endfunction

  // One clock: drive, check combinational view against the model, take the edge, update model.
  task automatic cycle(input logic fl, input logic iv, input logic [31:0] w, input logic rdy);
    logic        legal, ov, ir, acc, pop, stored;
    logic [25:0] hd;
    @(negedge clk);
    flush = fl; bus.in_valid = iv; bus.in_instr = w; bus.out_ready = rdy;
    #1;
    legal = (w[6:0] == OPV);
    ov    = (q.size() > 0);
    hd    = ov ? q[0] : 26'h0;
`ifdef V_IQ_BYPASS_EN
    if (!ov && iv && legal) begin ov = 1'b1; hd = w[31:7]; end
`endif
    ir = (q.size() < DEPTH) || ((q.size() > 0) && rdy);
    chk("count",     32'(bus.count), q.size());
    chk("empty",     bus.empty,      q.size() == 0);
    chk("full",      bus.full,       q.size() == DEPTH);
    chk("out_valid", bus.out_valid,  ov);
    chk("in_ready",  bus.in_ready,   ir);
    chk("illegal",   bus.illegal,    ill_m);
    if (ov) chk("head", head_w, hd);
    @(posedge clk);
    acc    = iv && ir;
    pop    = (q.size() > 0) && rdy;
    stored = acc && legal;
`ifdef V_IQ_BYPASS_EN
    if (q.size() == 0 && stored && rdy) stored = 1'b0;
`endif
    if (fl) begin
      q.delete();
      ill_m = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (stored) q.push_back(w[31:7]);
      ill_m = acc && !legal;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete();
    ill_m = 1'b0;
    chk("rst_count",     32'(bus.count), 0);
    chk("rst_empty",     bus.empty,      1);
    chk("rst_full",      bus.full,       0);
    chk("rst_out_valid", bus.out_valid,  0);
    chk("rst_in_ready",  bus.in_ready,   1);
    chk("rst_illegal",   bus.illegal,    0);
    chk("rst_fields",    head_w,         0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w1, w2, w3, w4, w5, addi;
    w1 = 32'h022081D7; w2 = 32'h12345657; w3 = 32'hABCDE0D7;
    w4 = 32'h55555557; w5 = 32'hFEDCBA57; addi = 32'h00000013;

    tbl[0]  = mk(1, w1,   0, 1, 0, 1, w1[31:7]);
    tbl[1]  = mk(1, addi, 0, 1, 1, 1, w1[31:7]);
    tbl[2]  = mk(0, 0,    0, 1, 0, 1, w1[31:7]);
    tbl[3]  = mk(1, w2,   0, 2, 0, 1, w1[31:7]);
    tbl[4]  = mk(1, w3,   0, 3, 0, 1, w1[31:7]);
    tbl[5]  = mk(1, w4,   0, 4, 0, 0, w1[31:7]);
    tbl[6]  = mk(1, w5,   0, 4, 0, 0, w1[31:7]);
    tbl[7]  = mk(1, w5,   1, 4, 0, 1, w2[31:7]);
    tbl[8]  = mk(0, 0,    1, 3, 0, 1, w3[31:7]);
    tbl[9]  = mk(0, 0,    1, 2, 0, 1, w4[31:7]);
    tbl[10] = mk(0, 0,    1, 1, 0, 1, w5[31:7]);
    tbl[11] = mk(0, 0,    1, 0, 0, 1, 0);

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    ill_m = 1'b0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, tbl[i].iv, tbl[i].w, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i),    32'(bus.count), tbl[i].cnt);
      chk($sformatf("tbl%0d_illegal", i),  bus.illegal,    tbl[i].ill);
      chk($sformatf("tbl%0d_full", i),     bus.full,       tbl[i].cnt == DEPTH);
      chk($sformatf("tbl%0d_in_ready", i), bus.in_ready,   tbl[i].ir);
      if (tbl[i].cnt > 0) chk($sformatf("tbl%0d_head", i), head_w, tbl[i].hd);
      if (i == 0) begin
        chk("vadd_funct6", bus.out_funct6, 0);
        chk("vadd_vm",     bus.out_vm,     1);
        chk("vadd_vs2",    bus.out_vs2,    2);
        chk("vadd_vs1",    bus.out_vs1,    1);
        chk("vadd_funct3", bus.out_funct3, 0);
        chk("vadd_vd",     bus.out_vd,     3);
      end
    end

    // Full queue streaming: pointers wrap twice, order checked by the model each cycle.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, legal_word(), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, legal_word(), 1'b1);
      chk("wrap_count", 32'(bus.count), DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Flush with a concurrent push and pop.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, legal_word(), 1'b0);
    cycle(1'b1, 1'b1, legal_word(), 1'b1);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_empty", bus.empty,      1);
`ifndef V_IQ_BYPASS_EN
    chk("flush_out_valid", bus.out_valid, 0);
`else
    cycle(1'b0, 1'b1, legal_word(), 1'b1);
    chk("byp_count", 32'(bus.count), 0);
`endif
    cycle(1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 800; i++) begin
      logic fl, iv, rdy;
      logic [31:0] w;
      fl  = ($urandom_range(0, 99) < 3);
      iv  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 45);
      w   = ($urandom_range(0, 99) < 80) ? legal_word() : illegal_word();
      cycle(fl, iv, w, rdy);
    end

    // Reset in the middle of traffic, then keep going.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, legal_word(), 1'b0);
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic iv, rdy;
      logic [31:0] w;
      iv  = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 40);
      w   = ($urandom_range(0, 99) < 85) ? legal_word() : illegal_word();
      cycle(1'b0, iv, w, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
